// File: rtl/code_lock_pkg.sv
// Shared definitions for the code lock controller: state encoding and its width.
package code_lock_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_LOCKED    = 3'd0,
    S_ENTER_LCK = 3'd1,
    S_OPEN      = 3'd2,
    S_ENTER_OPN = 3'd3,
    S_ENTER_NEW = 3'd4,
    S_LOCKOUT   = 3'd5
  } state_e;

  // True for the three states in which digits are being keyed in.
  function automatic logic is_entry(input state_e s);
    return (s == S_ENTER_LCK) || (s == S_ENTER_OPN) || (s == S_ENTER_NEW);
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Lockout duration timer: done rises on the last cycle of a LOCKOUT_CYC-long window.
module lock_timer #(
  parameter int LOCKOUT_CYC = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic done
);

  localparam int CNT_W = $clog2(LOCKOUT_CYC + 1);
  localparam logic [CNT_W-1:0] END_CNT = CNT_W'(LOCKOUT_CYC);

  logic [CNT_W-1:0] r_cnt;
  logic             r_run;

  // Counts cycles spent in the window starting at one, holding at the end value instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start) begin
      r_cnt <= CNT_W'(1);
      r_run <= 1'b1;
    end else if (clear) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (r_run && (r_cnt != END_CNT)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign done = r_run && (r_cnt == END_CNT);

endmodule

// File: rtl/code_lock_ctrl.sv
// Keypad code lock: digit entry, code compare, code change and timed lockout after repeated failures.
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_W     = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCKOUT_CYC = 100_000_000,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] RESET_CODE = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ent_p,
  input  logic                          clr_p,
  input  logic                          chg_p,
  input  logic [DIGIT_W-1:0]            sw,
  output logic [STATE_W-1:0]            state_o,
  output logic [2:0]                    digit_idx,
  output logic [NUM_DIGITS*DIGIT_W-1:0] entry_buf,
  output logic                          unlocked,
  output logic                          alarm,
  output logic [3:0]                    fail_cnt,
  output logic                          ok_p,
  output logic                          bad_p
);

  localparam int CODE_W = NUM_DIGITS * DIGIT_W;
  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);
  localparam logic [3:0] MAX_CNT  = 4'(MAX_TRIES);

  state_e            r_state;
  state_e            w_next;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] r_entry;
  logic [CODE_W-1:0] w_cand;
  logic [2:0]        r_idx;
  logic [3:0]        r_fail;
  logic [3:0]        w_fail_inc;
  logic              w_final;
  logic              w_match;
  logic              w_clear_entry;
  logic              w_latch_digit;
  logic              w_load_code;
  logic              w_fail_clr;
  logic              w_fail_step;
  logic              w_timer_start;
  logic              w_timer_clear;
  logic              w_timer_done;

  // The final digit is compared straight from the switches so the verdict lands on the same ent_p.
  assign w_cand     = {r_entry[CODE_W-1:DIGIT_W], sw};
  assign w_match    = (w_cand == r_code);
  assign w_final    = ent_p && (r_idx == LAST_IDX);
  assign w_fail_inc = (r_fail >= MAX_CNT) ? MAX_CNT : (r_fail + 4'd1);

  lock_timer #(
    .LOCKOUT_CYC(LOCKOUT_CYC)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .start(w_timer_start),
    .clear(w_timer_clear),
    .done (w_timer_done)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_LOCKED;
    else     r_state <= w_next;
  end

  // Next-state decode; ent_p outranks clr_p outranks chg_p, and unused codes fall back to LOCKED.
  always_comb begin
    w_next = S_LOCKED;
    case (r_state)
      S_LOCKED:    w_next = (ent_p || clr_p) ? S_ENTER_LCK : S_LOCKED;
      S_OPEN: begin
        if (ent_p || clr_p) w_next = S_ENTER_OPN;
        else if (chg_p)     w_next = S_ENTER_NEW;
        else                w_next = S_OPEN;
      end
      S_ENTER_LCK: begin
        if (!w_final)                w_next = S_ENTER_LCK;
        else if (w_match)            w_next = S_OPEN;
        else if (w_fail_inc == MAX_CNT) w_next = S_LOCKOUT;
        else                         w_next = S_LOCKED;
      end
      S_ENTER_OPN: begin
        if (!w_final)     w_next = S_ENTER_OPN;
        else if (w_match) w_next = S_LOCKED;
        else              w_next = S_OPEN;
      end
      S_ENTER_NEW: w_next = w_final ? S_OPEN : S_ENTER_NEW;
      S_LOCKOUT:   w_next = w_timer_done ? S_LOCKED : S_LOCKOUT;
      default:     w_next = S_LOCKED;
    endcase
  end

  // Status outputs, verdict pulses and datapath strobes derived from state and this cycle's pulses.
  always_comb begin
    unlocked      = 1'b0;
    alarm         = 1'b0;
    ok_p          = 1'b0;
    bad_p         = 1'b0;
    w_clear_entry = 1'b0;
    w_latch_digit = 1'b0;
    w_load_code   = 1'b0;
    w_fail_clr    = 1'b0;
    w_fail_step   = 1'b0;
    w_timer_start = 1'b0;
    w_timer_clear = 1'b0;
    if (is_entry(r_state)) begin
      if (ent_p) begin
        w_clear_entry = w_final;
        w_latch_digit = !w_final;
      end else if (clr_p) begin
        w_clear_entry = 1'b1;
      end
    end
    case (r_state)
      S_LOCKED: w_clear_entry = ent_p || clr_p;
      S_OPEN: begin
        unlocked      = 1'b1;
        w_clear_entry = ent_p || clr_p || chg_p;
      end
      S_ENTER_LCK: begin
        if (w_final) begin
          ok_p          = w_match;
          bad_p         = !w_match;
          w_fail_clr    = w_match;
          w_fail_step   = !w_match;
          w_timer_start = !w_match && (w_fail_inc == MAX_CNT);
        end
      end
      S_ENTER_OPN: begin
        unlocked = 1'b1;
        if (w_final) begin
          ok_p  = w_match;
          bad_p = !w_match;
        end
      end
      S_ENTER_NEW: begin
        unlocked = 1'b1;
        if (w_final) begin
          ok_p        = 1'b1;
          w_load_code = 1'b1;
        end
      end
      S_LOCKOUT: begin
        alarm = 1'b1;
        if (w_timer_done) begin
          w_timer_clear = 1'b1;
          w_fail_clr    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Entry buffer, digit index and stored code; digit 0 sits in the most significant slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_entry <= '0;
      r_idx   <= '0;
      r_code  <= RESET_CODE;
    end else begin
      if (w_clear_entry) begin
        r_entry <= '0;
        r_idx   <= '0;
      end else if (w_latch_digit) begin
        r_entry[(NUM_DIGITS - 1 - int'(r_idx)) * DIGIT_W +: DIGIT_W] <= sw;
        r_idx <= r_idx + 3'd1;
      end
      if (w_load_code) r_code <= w_cand;
    end
  end

  // Consecutive failure count while locked, saturating at the lockout threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_fail <= '0;
    else if (w_fail_clr)  r_fail <= '0;
    else if (w_fail_step) r_fail <= w_fail_inc;
  end

  assign state_o   = r_state;
  assign digit_idx = r_idx;
  assign entry_buf = r_entry;
  assign fail_cnt  = r_fail;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Bench for code_lock_ctrl: two configurations checked every cycle against a digit-level behavioural model.
module tb_code_lock_ctrl;

  localparam int LOCK_CYC = 20;
  localparam int MAX_T    = 3;

  typedef int codeT[8];

  logic        clk;
  logic        rst;
  logic        entP[2];
  logic        clrP[2];
  logic        chgP[2];
  logic [3:0]  swv[2];
  logic [2:0]  stateO[2];
  logic [2:0]  idxO[2];
  logic        unlO[2];
  logic        alarmO[2];
  logic [3:0]  failO[2];
  logic        okO[2];
  logic        badO[2];
  logic [15:0] eb0;
  logic [17:0] eb1;

  int ND[2] = '{4, 6};
  int DW[2] = '{4, 3};

  int mState[2];
  int mIdx[2];
  int mFail[2];
  int mLeft[2];
  int mBuf[2][8];
  int mCode[2][8];

  int checks = 0;
  int passed = 0;

  code_lock_ctrl #(
    .NUM_DIGITS(4), .DIGIT_W(4), .MAX_TRIES(MAX_T), .LOCKOUT_CYC(LOCK_CYC)
  ) dut0 (
    .clk(clk), .rst(rst), .ent_p(entP[0]), .clr_p(clrP[0]), .chg_p(chgP[0]), .sw(swv[0]),
    .state_o(stateO[0]), .digit_idx(idxO[0]), .entry_buf(eb0), .unlocked(unlO[0]),
    .alarm(alarmO[0]), .fail_cnt(failO[0]), .ok_p(okO[0]), .bad_p(badO[0])
  );

  code_lock_ctrl #(
    .NUM_DIGITS(6), .DIGIT_W(3), .MAX_TRIES(MAX_T), .LOCKOUT_CYC(LOCK_CYC)
  ) dut1 (
    .clk(clk), .rst(rst), .ent_p(entP[1]), .clr_p(clrP[1]), .chg_p(chgP[1]), .sw(swv[1][2:0]),
    .state_o(stateO[1]), .digit_idx(idxO[1]), .entry_buf(eb1), .unlocked(unlO[1]),
    .alarm(alarmO[1]), .fail_cnt(failO[1]), .ok_p(okO[1]), .bad_p(badO[1])
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic void clearEntry(input int i);
    mIdx[i] = 0;
    for (int k = 0; k < 8; k++) mBuf[i][k] = 0;
  endfunction

  function automatic void resetModel(input int i);
    mState[i] = 0;
    mFail[i]  = 0;
    mLeft[i]  = 0;
    clearEntry(i);
    for (int k = 0; k < 8; k++) mCode[i][k] = 0;
  endfunction

  function automatic logic [31:0] packBuf(input int i);
    logic [31:0] v = 0;
    for (int k = 0; k < ND[i]; k++) v = (v << DW[i]) | 32'(mBuf[i][k]);
    return v;
  endfunction

  function automatic logic [31:0] dutBuf(input int i);
    return (i == 0) ? 32'(eb0) : 32'(eb1);
  endfunction

  // Advance the model by one clock using the pulses currently applied; also yields the verdict pulses.
  task automatic modelStep(input int i, output bit expOk, output bit expBad);
    bit e, c, h, match;
    int s, nd;
    e = entP[i]; c = clrP[i]; h = chgP[i];
    s = int'(swv[i]) & ((1 << DW[i]) - 1);
    nd = ND[i];
    expOk = 0; expBad = 0;
    case (mState[i])
      0: if (e || c) begin mState[i] = 1; clearEntry(i); end
      2: begin
        if (e || c) begin mState[i] = 3; clearEntry(i); end
        else if (h) begin mState[i] = 4; clearEntry(i); end
      end
      1, 3, 4: begin
        if (e) begin
          if (mIdx[i] < nd - 1) begin
            mBuf[i][mIdx[i]] = s;
            mIdx[i]++;
          end else begin
            mBuf[i][nd-1] = s;
            match = 1;
            for (int k = 0; k < nd; k++) if (mBuf[i][k] != mCode[i][k]) match = 0;
            if (mState[i] == 4) begin
              for (int k = 0; k < 8; k++) mCode[i][k] = mBuf[i][k];
              expOk = 1; mState[i] = 2;
            end else if (mState[i] == 1) begin
              if (match) begin expOk = 1; mFail[i] = 0; mState[i] = 2; end
              else begin
                expBad = 1;
                mFail[i] = (mFail[i] + 1 > MAX_T) ? MAX_T : mFail[i] + 1;
                if (mFail[i] == MAX_T) begin mState[i] = 5; mLeft[i] = LOCK_CYC; end
                else mState[i] = 0;
              end
            end else begin
              if (match) begin expOk = 1; mState[i] = 0; end
              else begin expBad = 1; mState[i] = 2; end
            end
            clearEntry(i);
          end
        end else if (c) clearEntry(i);
      end
      5: begin
        mLeft[i]--;
        if (mLeft[i] == 0) begin mState[i] = 0; mFail[i] = 0; end
      end
      default: mState[i] = 0;
    endcase
  endtask

  task automatic checkRegs(input int i);
    checkOutput($sformatf("u%0d state", i), 32'(stateO[i]), 32'(mState[i]));
    checkOutput($sformatf("u%0d idx", i), 32'(idxO[i]), 32'(mIdx[i]));
    checkOutput($sformatf("u%0d entry_buf", i), dutBuf(i), packBuf(i));
    checkOutput($sformatf("u%0d unlocked", i), 32'(unlO[i]), 32'(mState[i] inside {2, 3, 4}));
    checkOutput($sformatf("u%0d alarm", i), 32'(alarmO[i]), 32'(mState[i] == 5));
    checkOutput($sformatf("u%0d fail_cnt", i), 32'(failO[i]), 32'(mFail[i]));
    checkOutput($sformatf("u%0d idle ok_p", i), 32'(okO[i]), 32'd0);
    checkOutput($sformatf("u%0d idle bad_p", i), 32'(badO[i]), 32'd0);
  endtask

  task automatic clearInputs();
    for (int i = 0; i < 2; i++) begin
      entP[i] = 0; clrP[i] = 0; chgP[i] = 0; swv[i] = 0;
    end
  endtask

  // One clock with whatever pulses are applied: verdicts checked before the edge, state after it.
  task automatic cycle();
    bit eo[2];
    bit eb[2];
    #1;
    for (int i = 0; i < 2; i++) begin
      modelStep(i, eo[i], eb[i]);
      checkOutput($sformatf("u%0d ok_p", i), 32'(okO[i]), 32'(eo[i]));
      checkOutput($sformatf("u%0d bad_p", i), 32'(badO[i]), 32'(eb[i]));
    end
    @(posedge clk);
    @(negedge clk);
    clearInputs();
    #1;
    checkRegs(0);
    checkRegs(1);
  endtask

  task automatic applyStimulus(input int i, input bit e, input bit c, input bit h, input int s);
    clearInputs();
    entP[i] = e; clrP[i] = c; chgP[i] = h; swv[i] = 4'(s);
    cycle();
  endtask

  // Asynchronous reset asserted between edges; outputs must already show the reset state.
  task automatic doReset();
    rst = 1;
    clearInputs();
    #1;
    resetModel(0);
    resetModel(1);
    checkRegs(0);
    checkRegs(1);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    checkRegs(0);
    checkRegs(1);
  endtask

  task automatic enterCode(input int i, input codeT code);
    applyStimulus(i, 0, 1, 0, 0);
    for (int k = 0; k < ND[i]; k++) applyStimulus(i, 1, 0, 0, code[k]);
  endtask

  task automatic changeCode(input int i, input codeT code);
    applyStimulus(i, 0, 0, 1, 0);
    for (int k = 0; k < ND[i]; k++) applyStimulus(i, 1, 0, 0, code[k]);
  endtask

  // Scenario walk for one configuration: unlock, change, relock, lockout, clear, abort by reset.
  task automatic directed(input int i, input codeT newc);
    codeT zeros = '{default: 0};
    codeT other = '{default: 7};
    doReset();
    enterCode(i, zeros);
    changeCode(i, newc);
    enterCode(i, newc);
    enterCode(i, zeros);
    enterCode(i, newc);
    enterCode(i, newc);
    repeat (3) enterCode(i, zeros);
    repeat (5) applyStimulus(i, 1, 1, 1, 0);
    repeat (LOCK_CYC) cycle();
    enterCode(i, zeros);
    applyStimulus(i, 0, 1, 0, 0);
    applyStimulus(i, 1, 0, 0, newc[0]);
    applyStimulus(i, 1, 0, 0, newc[1]);
    applyStimulus(i, 0, 1, 0, 0);
    enterCode(i, newc);
    applyStimulus(i, 0, 1, 0, 0);
    applyStimulus(i, 1, 1, 0, newc[0]);
    for (int k = 1; k < ND[i]; k++) applyStimulus(i, 1, 0, 0, newc[k]);
    enterCode(i, newc);
    applyStimulus(i, 0, 0, 1, 0);
    applyStimulus(i, 1, 0, 0, other[0]);
    applyStimulus(i, 1, 0, 0, other[1]);
    clearInputs();
    entP[i] = 1; swv[i] = 4'(other[2]);
    #2;
    doReset();
    enterCode(i, zeros);
  endtask

  initial begin
    codeT c0 = '{3, 10, 5, 1, 0, 0, 0, 0};
    codeT c1 = '{3, 2, 5, 1, 7, 6, 0, 0};
    rst = 0;
    clearInputs();
    doReset();
    directed(0, c0);
    directed(1, c1);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) doReset();
      for (int i = 0; i < 2; i++) begin
        entP[i] = ($urandom_range(0, 9) < 4);
        clrP[i] = ($urandom_range(0, 9) == 0);
        chgP[i] = ($urandom_range(0, 9) < 2);
        swv[i]  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      cycle();
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/code_lock_ctrl.md
CODE_LOCK_CTRL -- requirements
Module: code_lock_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4, digits per code, legal range 2..8.
REQ-002 Parameter DIGIT_W, default 4, bits per digit.
REQ-003 Parameter MAX_TRIES, default 3, consecutive wrong codes entered while locked that trigger lockout.
REQ-004 Parameter LOCKOUT_CYC, default 100_000_000, lockout duration in clk cycles.
REQ-005 Parameter RESET_CODE, default all zeros, width NUM_DIGITS*DIGIT_W, stored code after reset.
REQ-006 Port clk, input, 1 bit, system clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1 bit, reset, asynchronous, active-high.
REQ-008 Port ent_p, input, 1 bit, single-cycle enter pulse, already debounced.
REQ-009 Port clr_p, input, 1 bit, single-cycle clear pulse, already debounced.
REQ-010 Port chg_p, input, 1 bit, single-cycle change-code pulse, already debounced.
REQ-011 Port sw, input, DIGIT_W bits, current digit value.
REQ-012 Port state_o, output, 3 bits, encoded current state.
REQ-013 Port digit_idx, output, 3 bits, index of the digit being entered.
REQ-014 Port entry_buf, output, NUM_DIGITS*DIGIT_W bits, digits captured so far; digit 0 occupies the MSBs.
REQ-015 Port unlocked, output, 1 bit, high in OPEN, ENTER_OPEN and ENTER_NEW.
REQ-016 Port alarm, output, 1 bit, high in LOCKOUT.
REQ-017 Port fail_cnt, output, 4 bits, consecutive wrong codes entered while locked.
REQ-018 Port ok_p and bad_p, outputs, 1 bit each, single-cycle verdict pulses.

Function
REQ-019 States SHALL be LOCKED=0, ENTER_LCK=1, OPEN=2, ENTER_OPN=3, ENTER_NEW=4, LOCKOUT=5; codes 6 and 7 SHALL recover to LOCKED on the next cycle.
REQ-020 LOCKED: ent_p or clr_p -> ENTER_LCK with digit_idx=0 and entry_buf cleared.
REQ-021 OPEN: ent_p or clr_p -> ENTER_OPN; chg_p -> ENTER_NEW; both clear digit_idx and entry_buf.
REQ-022 Input priority in every state SHALL be ent_p > clr_p > chg_p; lower-priority pulses in the same cycle are ignored.
REQ-023 Entry states, ent_p with digit_idx<NUM_DIGITS-1: sw SHALL be latched into slot digit_idx and digit_idx incremented, both visible the next cycle.
REQ-024 Entry states, ent_p with digit_idx=NUM_DIGITS-1: the candidate SHALL be entry_buf with the current sw in the last slot, compared in the same cycle, with no extra latency.
REQ-025 ENTER_LCK final digit: match -> OPEN, ok_p, fail_cnt=0; mismatch -> fail_cnt+1, bad_p, then LOCKOUT if the new count equals MAX_TRIES, otherwise LOCKED.
REQ-026 ENTER_OPN final digit: match -> LOCKED, ok_p; mismatch -> OPEN, bad_p; fail_cnt unchanged.
REQ-027 ENTER_NEW final digit: the stored code SHALL be loaded with the candidate, then -> OPEN, ok_p; no comparison is made.
REQ-028 clr_p in any entry state SHALL zero entry_buf and digit_idx and keep the state; it does not count as a failure.
REQ-029 chg_p outside OPEN SHALL be ignored.
REQ-030 LOCKOUT SHALL ignore all pulses, stay for exactly LOCKOUT_CYC cycles, then enter LOCKED with fail_cnt=0.
REQ-031 The lockout counter SHALL be sized $clog2(LOCKOUT_CYC+1) and SHALL NOT wrap.
REQ-032 fail_cnt SHALL saturate at MAX_TRIES.
REQ-033 ok_p and bad_p SHALL never be high together and SHALL last one cycle each.

Reset
REQ-034 On rst: state LOCKED, stored code=RESET_CODE, entry_buf=0, digit_idx=0, fail_cnt=0, lockout counter=0, ok_p=bad_p=0, alarm=0, unlocked=0.
REQ-035 rst asserted mid-entry or mid-lockout SHALL abort immediately; no partial code is stored.

Structure
REQ-036 State encodings and the state_o width SHALL be placed in shared package code_lock_pkg.
REQ-037 The lockout timer SHALL be a separate sub-module lock_timer (inputs start and clear, output done).
REQ-038 Display mapping SHALL stay outside this block and be driven from state_o, digit_idx and entry_buf.

Verification
REQ-039 Reset, then enter 0,0,0,0 -> ok_p on the 4th ent_p, state_o=2 the next cycle, unlocked=1.
REQ-040 OPEN, chg_p, enter 3,A,5,1 -> state_o=2; relock with 3,A,5,1 -> state_o=0; 0,0,0,0 then fails with bad_p.
REQ-041 Three wrong codes from LOCKED (MAX_TRIES=3, LOCKOUT_CYC=20) -> alarm=1 for exactly 20 cycles, ent_p ignored, then state_o=0 and fail_cnt=0.
REQ-042 Enter 2 digits, clr_p, enter correct code -> ok_p, fail_cnt unchanged; ent_p and clr_p in the same cycle -> the digit is latched.
REQ-043 rst asserted during the 3rd digit of ENTER_NEW -> stored code reverts to RESET_CODE, state_o=0.
REQ-044 Repeat REQ-039..REQ-041 with NUM_DIGITS=6 and DIGIT_W=3.
